// File: rtl/prog_loader_pkg.sv
// Shared types and default geometry for the program loader and its bench.
package prog_loader_pkg;

    localparam int DEF_AW    = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 1 << DEF_AW;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/load_addr_counter.sv
// Saturating RAM address counter with a terminal flag and last-address capture.
// It is shared by the write sequence and the read-back sequence.
module load_addr_counter #(
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          incr,
    input  logic          capture,
    output logic [AW-1:0] count,
    output logic          terminal,
    output logic [AW-1:0] last_addr
);

    localparam logic [AW-1:0] TERM_VALUE = AW'(DEPTH - 1);

    logic [AW-1:0] count_reg, count_next;
    logic [AW-1:0] last_addr_reg, last_addr_next;

    // The counter stops at the top address instead of wrapping.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (incr && (count_reg != TERM_VALUE)) begin
            count_next = count_reg + 1'b1;
        end
        last_addr_next = capture ? count_reg : last_addr_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            last_addr_reg <= '0;
        end else begin
            count_reg     <= count_next;
            last_addr_reg <= last_addr_next;
        end
    end

    assign count     = count_reg;
    assign terminal  = (count_reg == TERM_VALUE);
    assign last_addr = last_addr_reg;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into the computer RAM and holds the CPU in program mode meanwhile.
// Optional read-back check of the loaded image is built when LOADER_VERIFY_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          fastClk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          prog_mode,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] checksum
);

    state_t        state_reg, state_next;
    logic [DW-1:0] checksum_reg, checksum_next;

    logic          cnt_clear, cnt_incr, cnt_capture;
    logic [AW-1:0] cnt_value;
    logic          cnt_terminal;
    logic [AW-1:0] cnt_last_addr;

    load_addr_counter #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_addr_counter (
        .clk       (fastClk),
        .rst_n     (rst),
        .clear     (cnt_clear),
        .incr      (cnt_incr),
        .capture   (cnt_capture),
        .count     (cnt_value),
        .terminal  (cnt_terminal),
        .last_addr (cnt_last_addr)
    );

`ifdef LOADER_VERIFY_EN
    logic [DW-1:0] rb_sum_reg, rb_sum_next;
    logic          vfy_issued_reg, vfy_issued_next;
    logic          rd_valid_reg, rd_valid_next;
    logic          rd_final_reg, rd_final_next;

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            rb_sum_reg     <= '0;
            vfy_issued_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_final_reg   <= 1'b0;
        end else begin
            rb_sum_reg     <= rb_sum_next;
            vfy_issued_reg <= vfy_issued_next;
            rd_valid_reg   <= rd_valid_next;
            rd_final_reg   <= rd_final_next;
        end
    end
`else
    logic unused_readback;
    assign unused_readback = ^{ram_rdata, cnt_last_addr};
`endif

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            checksum_reg <= '0;
        end else begin
            state_reg    <= state_next;
            checksum_reg <= checksum_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        checksum_next = checksum_reg;
        cnt_clear     = 1'b0;
        cnt_incr      = 1'b0;
        cnt_capture   = 1'b0;
`ifdef LOADER_VERIFY_EN
        rb_sum_next     = rb_sum_reg;
        vfy_issued_next = vfy_issued_reg;
        rd_valid_next   = 1'b0;
        rd_final_next   = 1'b0;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next    = ST_LOAD;
                    cnt_clear     = 1'b1;
                    checksum_next = '0;
                end
            end
            ST_LOAD: begin
                // in_ready is constantly high here, so in_valid alone is the handshake.
                if (in_valid) begin
                    checksum_next = checksum_reg + in_data;
                    cnt_incr      = 1'b1;
                    if (in_last || cnt_terminal) begin
                        cnt_capture = 1'b1;
`ifdef LOADER_VERIFY_EN
                        state_next      = ST_VERIFY;
                        cnt_clear       = 1'b1;
                        rb_sum_next     = '0;
                        vfy_issued_next = 1'b0;
`else
                        state_next      = ST_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                // Addresses are issued first, data returns one cycle behind them.
                if (!vfy_issued_reg) begin
                    rd_valid_next   = 1'b1;
                    rd_final_next   = (cnt_value == cnt_last_addr);
                    vfy_issued_next = rd_final_next;
                    cnt_incr        = !rd_final_next;
                end
                if (rd_valid_reg) begin
                    rb_sum_next = rb_sum_reg + ram_rdata;
                end
                if (rd_final_reg) begin
                    state_next = (rb_sum_next == checksum_reg) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_LOAD);
        ram_we    = (state_reg == ST_LOAD) && in_valid;
        prog_mode = (state_reg != ST_DONE);
        busy      = (state_reg == ST_LOAD) || (state_reg == ST_VERIFY);
        done      = (state_reg == ST_DONE);
`ifdef LOADER_VERIFY_EN
        error     = (state_reg == ST_ERROR);
`else
        error     = 1'b0;
`endif
    end

    assign ram_addr  = cnt_value;
    assign ram_wdata = in_data;
    assign checksum  = checksum_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a behavioural RAM/checksum model.
// Adapts its expectations when LOADER_VERIFY_EN is defined.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int AW    = DEF_AW;
    localparam int DW    = DEF_DW;
    localparam int DEPTH = DEF_DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          prog_mode;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    prog_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .fastClk   (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .prog_mode (prog_mode),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    // Bench-side RAM (the device under load) and the reference image.
    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] fill_mem [DEPTH];
    logic [DW-1:0] exp_mem  [DEPTH];
    logic [DW-1:0] stim     [DEPTH];
    logic [DW-1:0] exp_sum;
    logic          fill;
    logic          corrupt;
    int            wr_count;
    int            n_tests = 0;
    int            n_fail  = 0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= fill_mem[i];
            wr_count <= 0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
        end
        ram_rdata <= mem[ram_addr] ^ ((corrupt && ram_addr == AW'(2)) ? 8'h40 : 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("prog_mode_after_start", {31'd0, prog_mode}, 32'd1);
        check("in_ready_after_start", {31'd0, in_ready}, 32'd1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        exp_sum = '0;
    endtask

    task automatic send_bytes(input int n, input bit use_last, input int gap_min, input int gap_max);
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(gap_max, gap_min);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom_range(1, 0));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = use_last && (i == n - 1);
            @(negedge clk);
            exp_mem[i] = stim[i];
            exp_sum    = exp_sum + stim[i];
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_load(input int n, input bit exp_err, input int base);
        int lat;
        int exp_lat;
        lat = 0;
`ifdef LOADER_VERIFY_EN
        exp_lat = n + 1;
`else
        exp_lat = 0;
`endif
        while (!(done || error) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("end_latency", lat, exp_lat);
        check("done", {31'd0, done}, {31'd0, !exp_err});
        check("error", {31'd0, error}, {31'd0, exp_err});
        check("prog_mode_end", {31'd0, prog_mode}, {31'd0, exp_err});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("in_ready_end", {31'd0, in_ready}, 32'd0);
        check("checksum", {24'd0, checksum}, {24'd0, exp_sum});
        check("write_count", wr_count - base, n);
        for (int a = 0; a < DEPTH; a++)
            check($sformatf("ram[%0d]", a), {24'd0, mem[a]}, {24'd0, exp_mem[a]});
        $display("[TB] load n=%0d err=%0b latency=%0d checksum=%02h", n, exp_err, lat, checksum);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_prog_mode"}, {31'd0, prog_mode}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        bit use_last;

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b0;
        corrupt  = 1'b0;
        fill     = 1'b1;
        exp_sum  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fill_mem[i] = 8'($urandom);
            exp_mem[i]  = fill_mem[i];
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_ram_addr", {28'd0, ram_addr}, 32'd0);
        fill = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check_idle("idle");

        // start and in_valid together: only start acts.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("collision_no_write", wr_count, 0);
        in_data = 8'h5A;
        in_last = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        exp_mem[0] = 8'h5A;
        exp_sum    = 8'h5A;
        $display("[TB] collision: start+valid then 0x5A");
        finish_load(1, 1'b0, 0);

        // Full back-to-back load 0x01..0x10.
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'(i + 1);
        pulse_start();
        base = wr_count;
        send_bytes(DEPTH, 1'b0, 0, 0);
        finish_load(DEPTH, 1'b0, base);
        check("full_checksum", {24'd0, checksum}, 32'h88);
        in_valid = 1'b1;
        in_data  = 8'h77;
        check("extra_byte_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("extra_byte_no_write", wr_count - base, DEPTH);
        in_valid = 1'b0;

        // Reload from DONE.
        stim[0] = 8'hAA;
        pulse_start();
        base = wr_count;
        send_bytes(1, 1'b1, 0, 0);
        finish_load(1, 1'b0, base);

        // Short load with idle gaps between bytes.
        stim[0] = 8'h1E;
        stim[1] = 8'h2F;
        stim[2] = 8'hF0;
        pulse_start();
        base = wr_count;
        send_bytes(3, 1'b1, 1, 3);
        finish_load(3, 1'b0, base);
        check("short_checksum", {24'd0, checksum}, 32'h3D);

`ifdef LOADER_VERIFY_EN
        for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
        corrupt = 1'b1;
        pulse_start();
        base = wr_count;
        send_bytes(4, 1'b1, 0, 0);
        finish_load(4, 1'b1, base);
        corrupt = 1'b0;
        pulse_start();
        base = wr_count;
        send_bytes(4, 1'b1, 0, 0);
        finish_load(4, 1'b0, base);
`endif

        // Random lengths, data and gaps.
        repeat (6) begin
            n        = $urandom_range(DEPTH, 1);
            use_last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(1, 0));
            for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
            pulse_start();
            base = wr_count;
            send_bytes(n, use_last, 0, 2);
            finish_load(n, 1'b0, base);
        end

        // Reset in the middle of a load.
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
        pulse_start();
        send_bytes(5, 1'b0, 0, 0);
        rst = 1'b0;
        #1;
        check_idle("midload_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd0);
        for (int a = 0; a < DEPTH; a++)
            check($sformatf("reset_ram[%0d]", a), {24'd0, mem[a]}, {24'd0, exp_mem[a]});
        $display("[TB] reset after 5 bytes");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
